acc_drain_fp16: RTL and testbench

- Downstream stage of the mm systolic wrapper.
- On the array's done pulse, snapshots every PE's (exp, acc) pair: 5-bit shared exponent and signed fixed-point accumulator.
- Converts each pair to IEEE FP16 (round-to-nearest-even).
- Streams the results out one per beat over a valid/ready interface, in row-major PE order, for write-back to activation memory.

---
 rtl/acc_drain_fp16.sv | 175 +++++++++++++++++
 tb/tb_acc_drain_fp16.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain_fp16.sv
// rtl/acc_drain_fp16.sv - snapshot PE (exp, acc) pairs on done and stream them out as FP16
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   done                  array-complete pulse; captures all PE pairs when idle
//   exp_in                PE l exponent at [l*EXP_WIDTH +: EXP_WIDTH]
//   acc_in                PE l accumulator at [l*ACC_WIDTH +: ACC_WIDTH]
//   out_valid/out_ready   result handshake, one beat per accepted transfer
//   out_data              FP16 result (round-to-nearest-even, no subnormals)
//   out_idx               PE index (row*N + col) of out_data
//   out_last              marks the beat for PE N*N-1
//   busy                  a snapshot is held and not all beats are accepted
//   overrun               sticky: done arrived while busy
module acc_drain_fp16 #(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32,
    parameter int ACC_FRAC  = 10,
    parameter int EXP_WIDTH = 5,
    parameter int IDX_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    input  logic [N*N*EXP_WIDTH-1:0]     exp_in,
    input  logic [N*N*ACC_WIDTH-1:0]     acc_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic [IDX_WIDTH-1:0]         out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int NN   = N * N;
    localparam int PW   = $clog2(ACC_WIDTH);
    localparam int EW   = PW + EXP_WIDTH + 3;
    // One extra bit so the pointer can reach NN even when 2^IDX_WIDTH == NN.
    localparam int PTRW = IDX_WIDTH + 1;
    localparam logic [PTRW-1:0] NN_P   = PTRW'(NN);
    localparam logic [PTRW-1:0] LAST_P = PTRW'(NN - 1);

    typedef enum logic [0:0] {IDLE, DRAIN} state_t;

    state_t state, state_next;

    logic [EXP_WIDTH-1:0] snap_exp [NN];
    logic [ACC_WIDTH-1:0] snap_acc [NN];
    logic [PTRW-1:0]      ptr;

    logic                 capture;
    logic                 load;
    logic                 finish;
    logic [EXP_WIDTH-1:0] sel_exp;
    logic [ACC_WIDTH-1:0] sel_acc;
    logic [15:0]          conv_data;

    function automatic logic [15:0] conv(input logic [EXP_WIDTH-1:0] e,
                                         input logic [ACC_WIDTH-1:0] a);
        logic                 s;
        logic [ACC_WIDTH-1:0] m;
        logic [ACC_WIDTH-1:0] norm;
        logic [PW-1:0]        p;
        logic [PW:0]          sh;
        logic [9:0]           mant;
        logic                 g;
        logic                 st;
        logic [10:0]          mr;
        logic signed [EW-1:0] eb;
        logic [15:0]          r;
        s = a[ACC_WIDTH-1];
        // Two's complement negate; the most negative value maps to 2^(W-1).
        m = s ? (~a + 1'b1) : a;
        p = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (m[i]) p = PW'(i);
        end
        // Shift the leading one out the top so the mantissa sits at the MSBs;
        // low bits beyond the magnitude fill with zeros.
        sh   = (PW + 1)'(ACC_WIDTH) - {1'b0, p};
        norm = m << sh;
        mant = norm[ACC_WIDTH-1 -: 10];
        g    = norm[ACC_WIDTH-11];
        st   = |norm[ACC_WIDTH-12:0];
        mr   = {1'b0, mant} + 11'(g && (st || mant[0]));
        // Mantissa carry-out leaves mr[9:0] == 0 and bumps the exponent.
        eb   = EW'(p) + EW'(e) + EW'(mr[10]) - EW'(ACC_FRAC);
        if (m == '0)
            r = 16'h0000;
        else if (eb >= 31)
            r = {s, 5'h1F, 10'h000};
        else if (eb <= 0)
            r = {s, 15'h0000};
        else
            r = {s, eb[4:0], mr[9:0]};
        return r;
    endfunction

    always_comb begin
        sel_exp = '0;
        sel_acc = '0;
        for (int i = 0; i < NN; i++) begin
            if (ptr == PTRW'(i)) begin
                sel_exp = snap_exp[i];
                sel_acc = snap_acc[i];
            end
        end
    end

    assign conv_data = conv(sel_exp, sel_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (done) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                load   = (!out_valid || out_ready) && (ptr < NN_P);
                finish = out_valid && out_ready && out_last && !load;
                if (finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                snap_exp[i] <= '0;
                snap_acc[i] <= '0;
            end
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NN; i++) begin
                    snap_exp[i] <= exp_in[i*EXP_WIDTH +: EXP_WIDTH];
                    snap_acc[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
                end
                ptr <= '0;
            end
            // Includes the completion cycle: a done there is not captured.
            if (done && state == DRAIN) overrun <= 1'b1;
            if (load) begin
                out_data  <= conv_data;
                out_idx   <= ptr[IDX_WIDTH-1:0];
                out_last  <= (ptr == LAST_P);
                out_valid <= 1'b1;
                ptr       <= ptr + 1'b1;
            end else if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign busy = (state == DRAIN);

endmodule

// File: tb/tb_acc_drain_fp16.sv
// tb/tb_acc_drain_fp16.sv - directed and randomized checks of acc_drain_fp16 against an arithmetic model
module tb_acc_drain_fp16;

    localparam int N  = 2;
    localparam int NN = N * N;
    localparam int AW = 32;
    localparam int EW = 5;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              done = 1'b0;
    logic [NN*EW-1:0]  exp_in = '0;
    logic [NN*AW-1:0]  acc_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              busy;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    int beat_idx = 0;

    logic [15:0] exp_q [$];
    logic [31:0] va [NN];
    logic [4:0]  ve [NN];

    acc_drain_fp16 #(.N(N), .ACC_WIDTH(AW), .ACC_FRAC(10), .EXP_WIDTH(EW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .done(done), .exp_in(exp_in), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Value = a * 2^-10 * 2^(e-15); rounding done on the integer remainder.
    function automatic logic [15:0] ref_conv(input logic [4:0] e, input logic [31:0] a);
        longint v, mag, q, rem, half;
        int     p, ee, sh;
        logic   s;
        v   = longint'($signed(a));
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 16'h0000;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        ee = p - 10 + int'(e);
        if (p <= 10) begin
            q = mag << (10 - p);
        end else begin
            sh   = p - 10;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == 2048) begin
            q  = 1024;
            ee = ee + 1;
        end
        if (ee >= 31) return {s, 15'h7C00};
        if (ee <= 0)  return {s, 15'h0000};
        return {s, ee[4:0], q[9:0]};
    endfunction

    task automatic set_bus();
        for (int i = 0; i < NN; i++) begin
            exp_in[i*EW +: EW] = ve[i];
            acc_in[i*AW +: AW] = va[i];
        end
    endtask

    task automatic push_model();
        for (int i = 0; i < NN; i++) exp_q.push_back(ref_conv(ve[i], va[i]));
    endtask

    task automatic push_const(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
        exp_q.push_back(c3);
    endtask

    task automatic randomize_vals();
        for (int i = 0; i < NN; i++) begin
            ve[i] = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: va[i] = $urandom;
                1: va[i] = 32'($urandom_range(0, 8191));
                2: va[i] = -32'($urandom_range(1, 70000));
                default: va[i] = 32'($urandom_range(0, 3));
            endcase
        end
    endtask

    // Called at posedge+1; done is sampled at the next edge (E0).
    task automatic pulse_done(input string tag);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        beat_idx = 0;
        check({tag, "_busy_after_done"}, 32'(busy), 32'd1);
        check({tag, "_valid_after_done"}, 32'(out_valid), 32'd0);
    endtask

    // mode 0: ready tied high; 1: fixed 1,0,0,1,0,1,1 pattern; 2: random.
    task automatic drain(input string tag, input int mode, input int nbeats, output int cyc);
        int          got;
        int          k;
        logic        stall;
        logic [15:0] hd;
        logic [IW-1:0] hi;
        logic        hl;
        logic [15:0] e;
        bit          pat [7];
        pat   = '{1, 0, 0, 1, 0, 1, 1};
        got   = 0;
        cyc   = 0;
        k     = 0;
        stall = 1'b0;
        hd    = '0;
        hi    = '0;
        hl    = 1'b0;
        while (got < nbeats && cyc < 100) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[k % 7];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
            stall = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_beat"}, 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_data"}, 32'(out_data), 32'(e));
                    check({tag, "_idx"}, 32'(out_idx), 32'(beat_idx));
                    check({tag, "_last"}, 32'(out_last), 32'(beat_idx == NN - 1));
                end
                beat_idx++;
                got++;
            end else if (out_valid) begin
                stall = 1'b1;
                hd = out_data;
                hi = out_idx;
                hl = out_last;
            end
            @(posedge clk); #1;
            cyc++;
            if (stall) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_data"}, 32'(out_data), 32'(hd));
                check({tag, "_hold_idx"}, 32'(out_idx), 32'(hi));
                check({tag, "_hold_last"}, 32'(out_last), 32'(hl));
            end
        end
        if (got < nbeats) check({tag, "_timeout_beats"}, 32'(got), 32'(nbeats));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_end_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_group(input int g);
        case (g)
            0: begin
                va = '{32'hFFFFC800, 32'hFFFFAC00, 32'hFFFFA800, 32'hFFFF9000};
                ve = '{5'd15, 5'd15, 5'd15, 5'd15};
            end
            1: begin
                va = '{32'h00000401, 32'h00000C01, 32'h00001003, 32'h00001002};
                ve = '{5'd15, 5'd15, 5'd15, 5'd15};
            end
            2: begin
                va = '{32'h00001FFE, 32'h7FFFFFFF, 32'h80000000, 32'h00000001};
                ve = '{5'd15, 5'd31, 5'd0, 5'd0};
            end
            default: begin
                va = '{32'hFFFFFFFF, 32'h00000000, 32'h00000400, 32'h00000400};
                ve = '{5'd0, 5'd15, 5'd0, 5'd1};
            end
        endcase
    endtask

    task automatic push_group(input int g);
        case (g)
            0:       push_const(16'hCB00, 16'hCD40, 16'hCD80, 16'hCF00);
            1:       push_const(16'h3C01, 16'h4200, 16'h4401, 16'h4400);
            2:       push_const(16'h4800, 16'h7C00, 16'hD400, 16'h0000);
            default: push_const(16'h8000, 16'h0000, 16'h0000, 16'h0400);
        endcase
    endtask

    initial begin
        int cyc;
        #3;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_idx", 32'(out_idx), 32'd0);
        check("reset_last", 32'(out_last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle: input changes and out_ready without done do nothing.
        for (int i = 0; i < 3; i++) begin
            randomize_vals();
            set_bus();
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Ready tied high: NN beats back to back, busy drops after the last accept.
        set_group(0); set_bus(); push_group(0);
        pulse_done("g0");
        drain("g0", 0, NN, cyc);
        check("g0_drain_cycles", 32'(cyc), 32'(NN + 1));
        check_idle("g0");
        check("g0_overrun", 32'(overrun), 32'd0);

        set_group(0); set_bus(); push_group(0);
        pulse_done("g0_stall");
        drain("g0_stall", 1, NN, cyc);
        check_idle("g0_stall");

        for (int g = 1; g < 4; g++) begin
            set_group(g); set_bus(); push_group(g);
            pulse_done("directed");
            drain("directed", g % 3, NN, cyc);
            check_idle("directed");
        end

        for (int r = 0; r < 12; r++) begin
            randomize_vals(); set_bus(); push_model();
            pulse_done("random");
            drain("random", 2, NN, cyc);
            check_idle("random");
        end

        // done again while stalled at E0+2: overrun set, original snapshot still drained.
        set_group(0); set_bus(); push_group(0);
        pulse_done("ovr");
        out_ready = 1'b0;
        @(posedge clk); #1;
        randomize_vals(); set_bus();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_held_data", 32'(out_data), 32'hCB00);
        drain("ovr", 0, NN, cyc);
        check_idle("ovr");
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a drain, then a fresh drain from idx 0.
        set_group(1); set_bus(); push_group(1);
        pulse_done("rst");
        drain("rst", 0, 2, cyc);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_idx", 32'(out_idx), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'd0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        set_group(2); set_bus(); push_group(2);
        pulse_done("post_rst");
        drain("post_rst", 2, NN, cyc);
        check_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
